// File: rtl/axicb_mst_rd_ostdg_ctrl.sv
// ---------------------------------------------------------------------------
// axicb_mst_rd_ostdg_ctrl
// Read-path outstanding-request controller sitting between one master agent
// and its read switch. Tracks in-flight reads (AR accepted, RLAST not yet
// returned), caps them at MAX_OSTDG, and holds back any AR whose decoded
// target differs from the target of the reads already in flight. Keeping all
// outstanding reads on one slave (or the DECERR path) means R data and RLAST
// framing always come back to the master in issue order.
//
// Ports
//   aclk, aresetn, srst    clock, async active-low reset, sync active-high reset
//   s_ar*                  AR channel from the master
//   s_r*                   R channel to the master (wired straight through)
//   m_ar*                  AR channel to the switch
//   m_r*                   R channel from the switch
//   ostdg_cnt              current number of in-flight reads
//   ar_stalled             master is presenting an AR that this block is holding
// ---------------------------------------------------------------------------
module axicb_mst_rd_ostdg_ctrl #(
    parameter int                    AXI_ADDR_W      = 8,
    parameter int                    ARCH_W          = 8,
    parameter int                    RCH_W           = 8,
    parameter int                    SLV_NB          = 4,
    parameter int                    MAX_OSTDG       = 4,
    parameter logic [3:0]            MST_ROUTES      = 4'b1111,
    parameter logic [AXI_ADDR_W-1:0] SLV0_START_ADDR = 'h00,
    parameter logic [AXI_ADDR_W-1:0] SLV0_END_ADDR   = 'h0F,
    parameter logic [AXI_ADDR_W-1:0] SLV1_START_ADDR = 'h10,
    parameter logic [AXI_ADDR_W-1:0] SLV1_END_ADDR   = 'h7F,
    parameter logic [AXI_ADDR_W-1:0] SLV2_START_ADDR = 'h80,
    parameter logic [AXI_ADDR_W-1:0] SLV2_END_ADDR   = 'hBF,
    parameter logic [AXI_ADDR_W-1:0] SLV3_START_ADDR = 'hC0,
    parameter logic [AXI_ADDR_W-1:0] SLV3_END_ADDR   = 'hFF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              srst,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ARCH_W-1:0] s_arch,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              s_rlast,
    output logic [RCH_W-1:0]  s_rch,
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ARCH_W-1:0] m_arch,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic              m_rlast,
    input  logic [RCH_W-1:0]  m_rch,
    output logic [7:0]        ostdg_cnt,
    output logic              ar_stalled
);

    localparam logic [AXI_ADDR_W-1:0] SLV_START [4] = '{
        SLV0_START_ADDR, SLV1_START_ADDR, SLV2_START_ADDR, SLV3_START_ADDR};
    localparam logic [AXI_ADDR_W-1:0] SLV_END [4] = '{
        SLV0_END_ADDR, SLV1_END_ADDR, SLV2_END_ADDR, SLV3_END_ADDR};
    localparam logic [7:0] CNT_MAX  = 8'(MAX_OSTDG);
    localparam logic [2:0] TGT_MISR = 3'(SLV_NB);

    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_ADDR_W-1:0] offs;
    logic [2:0]            tgt;
    logic [7:0]            cnt;
    logic [2:0]            cur_tgt;
    logic                  block;
    logic                  ar_hs;
    logic                  r_done;

    assign addr = s_arch[AXI_ADDR_W-1:0];

    // Window hit is tested as (addr - start) <= (end - start) with wrap-around
    // subtraction, which is equivalent to start <= addr <= end for a well
    // formed window. Walking from the top index down lets the lowest matching
    // slave win.
    always_comb begin
        tgt  = TGT_MISR;
        offs = '0;
        for (int i = SLV_NB - 1; i >= 0; i--) begin
            offs = addr - SLV_START[i];
            if (MST_ROUTES[i] && (offs <= (SLV_END[i] - SLV_START[i])))
                tgt = 3'(i);
        end
    end

    // Block is built only from registered state and the master's AR payload,
    // so there is no path from m_arready back to m_arvalid.
    assign block      = (cnt == CNT_MAX) || ((cnt != 8'd0) && (tgt != cur_tgt));
    assign m_arvalid  = s_arvalid & ~block;
    assign s_arready  = m_arready & ~block;
    assign m_arch     = s_arch;
    assign ar_stalled = s_arvalid & block;

    assign s_rvalid = m_rvalid;
    assign s_rlast  = m_rlast;
    assign s_rch    = m_rch;
    assign m_rready = s_rready;

    assign ar_hs  = s_arvalid & s_arready;
    assign r_done = m_rvalid & m_rready & m_rlast;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt     <= 8'd0;
            cur_tgt <= 3'd0;
        end else if (srst) begin
            cnt     <= 8'd0;
            cur_tgt <= 3'd0;
        end else begin
            if (ar_hs)
                cur_tgt <= tgt;
            if (ar_hs && !r_done) begin
                if (cnt != CNT_MAX)
                    cnt <= cnt + 8'd1;
            end else if (r_done && !ar_hs) begin
                // RLAST with nothing in flight is a protocol error; stay at 0.
                if (cnt != 8'd0)
                    cnt <= cnt - 8'd1;
            end
        end
    end

    assign ostdg_cnt = cnt;

endmodule
